sha256_compress_block: RTL and testbench

- One SHA-256 compression (64 rounds) of a single 512-bit message block.
- The initial chaining value (h_init) and the initial working state (alpha_init) are supplied separately.
- Returns the updated chaining value (hash) and the final working state (alpha).
- Used as a replicated worker inside the bitcoin hashing top level; several instances run in parallel, all driven by one shared start.

---
 rtl/sha256_compress_block.sv | 128 ++++++++++++
 tb/tb_sha256_compress_block.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/sha256_compress_block.sv
// One SHA-256 compression of a 512-bit block: h_init + 64 rounds over alpha_init.
// Define SHA256_TWO_ROUNDS_EN to run two chained rounds per clock (33-cycle latency instead of 65).
module sha256_compress_block #(
  parameter int ROUNDS = 64
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [511:0] memory_block,
  input  logic [31:0]  h_init     [8],
  input  logic [31:0]  alpha_init [8],
  output logic [31:0]  hash       [8],
  output logic [31:0]  alpha      [8],
  output logic         done
);

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL} state_t;

  localparam logic [31:0] K_TAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ss0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ss1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  // Working state packed as {a,b,c,d,e,f,g,h}, a in the MSBs.
  function automatic logic [255:0] round_f(input logic [255:0] s, input logic [31:0] k,
                                           input logic [31:0] w);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    {a, b, c, d, e, f, g, h} = s;
    t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
    t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
    return {t1 + t2, a, b, c, d + t1, e, f, g};
  endfunction

  state_t       r_state;
  logic [5:0]   r_t;
  logic [255:0] r_st;
  logic [31:0]  r_h [8];
  logic [31:0]  r_w [16];   // r_w[0] is W_t, r_w[15] is W_t+15

  logic [255:0] w_st;
  logic [31:0]  w_new0;
  assign w_new0 = ss1(r_w[14]) + r_w[9] + ss0(r_w[1]) + r_w[0];

`ifdef SHA256_TWO_ROUNDS_EN
  localparam logic [5:0] STEP = 6'd2;
  localparam logic [5:0] LAST = 6'(ROUNDS - 2);
  logic [31:0]  w_new1;
  logic [255:0] w_mid;
  assign w_new1 = ss1(r_w[15]) + r_w[10] + ss0(r_w[2]) + r_w[1];
  assign w_mid  = round_f(r_st, K_TAB[r_t], r_w[0]);
  assign w_st   = round_f(w_mid, K_TAB[{r_t[5:1], 1'b1}], r_w[1]);
`else
  localparam logic [5:0] STEP = 6'd1;
  localparam logic [5:0] LAST = 6'(ROUNDS - 1);
  assign w_st = round_f(r_st, K_TAB[r_t], r_w[0]);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_t     <= '0;
      r_st    <= '0;
      done    <= 1'b0;
      for (int j = 0; j < 8; j++) begin
        r_h[j]   <= '0;
        hash[j]  <= '0;
        alpha[j] <= '0;
      end
      for (int i = 0; i < 16; i++) r_w[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            for (int i = 0; i < 16; i++) r_w[i] <= memory_block[511-32*i -: 32];
            for (int j = 0; j < 8; j++) begin
              r_h[j]              <= h_init[j];
              r_st[255-32*j -: 32] <= alpha_init[j];
            end
            done    <= 1'b0;
            r_t     <= '0;
            r_state <= S_ROUND;
          end
        end
        S_ROUND: begin
          r_st <= w_st;
`ifdef SHA256_TWO_ROUNDS_EN
          for (int i = 0; i < 14; i++) r_w[i] <= r_w[i+2];
          r_w[14] <= w_new0;
          r_w[15] <= w_new1;
`else
          for (int i = 0; i < 15; i++) r_w[i] <= r_w[i+1];
          r_w[15] <= w_new0;
`endif
          r_t <= r_t + STEP;
          if (r_t == LAST) r_state <= S_FINAL;
        end
        S_FINAL: begin
          for (int j = 0; j < 8; j++) begin
            alpha[j] <= r_st[255-32*j -: 32];
            hash[j]  <= r_h[j] + r_st[255-32*j -: 32];
          end
          done    <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_compress_block.sv
// Scoreboard bench for sha256_compress_block: known digests, latency, busy-start, reset abort, done hold.
module tb_sha256_compress_block;

`ifdef SHA256_TWO_ROUNDS_EN
  localparam int LAT = 33;
`else
  localparam int LAT = 65;
`endif

  localparam logic [255:0] IV       = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC_H    = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY_H  = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] TWO_H    = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [511:0] ABC_B    = {32'h61626380, 416'h0, 32'h00000000, 32'h00000018};
  localparam logic [511:0] EMPTY_B  = {32'h80000000, 480'h0};
  localparam logic [511:0] TWO_B1   = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                       32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                       32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                       32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] TWO_B2   = {448'h0, 32'h00000000, 32'h000001c0};

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [511:0] memory_block = '0;
  logic [255:0] hin_p = '0;
  logic [255:0] ain_p = '0;
  logic [31:0]  h_init [8];
  logic [31:0]  alpha_init [8];
  logic [31:0]  hash [8];
  logic [31:0]  alpha [8];
  logic         done;
  logic [255:0] hash_p, alpha_p, last_hash;

  int n_chk = 0;
  int n_fail = 0;

  logic [255:0] exp_hash_q [$];
  logic [255:0] exp_hin_q  [$];

  always #5 clk = ~clk;

  always_comb begin
    for (int j = 0; j < 8; j++) begin
      h_init[j]     = hin_p[255-32*j -: 32];
      alpha_init[j] = ain_p[255-32*j -: 32];
    end
  end
  assign hash_p  = {hash[0], hash[1], hash[2], hash[3], hash[4], hash[5], hash[6], hash[7]};
  assign alpha_p = {alpha[0], alpha[1], alpha[2], alpha[3], alpha[4], alpha[5], alpha[6], alpha[7]};

  sha256_compress_block dut (
    .clk(clk), .reset_n(reset_n), .start(start), .memory_block(memory_block),
    .h_init(h_init), .alpha_init(alpha_init), .hash(hash), .alpha(alpha), .done(done)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] lane_sub(input logic [255:0] x, input logic [255:0] y);
    logic [255:0] r;
    for (int j = 0; j < 8; j++) r[255-32*j -: 32] = x[255-32*j -: 32] - y[255-32*j -: 32];
    return r;
  endfunction

  // disturb: re-pulse start with a different block while the engine is busy
  task automatic run_block(input string tag, input logic [511:0] blk, input logic [255:0] hin,
                           input logic [255:0] ain, input bit has_exp, input logic [255:0] exp,
                           input bit disturb);
    int  lat;
    bit  got;
    logic [255:0] eh, ei;
    if (has_exp) begin
      exp_hash_q.push_back(exp);
      exp_hin_q.push_back(hin);
    end
    @(negedge clk);
    memory_block = blk;
    hin_p = hin;
    ain_p = ain;
    start = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, "_done_clr"}, 256'(done), 256'd0);
    @(negedge clk);
    start = 1'b0;
    memory_block = {16{32'hdeadbeef}};
    hin_p = ~hin;
    ain_p = ~ain;
    lat = 0;
    got = 1'b0;
    for (int c = 1; c <= 200 && !got; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        got = 1'b1;
        lat = c;
      end else if (disturb && c == 10) begin
        start = 1'b1;
        memory_block = {$urandom, $urandom, $urandom, $urandom, 384'h0};
      end else if (disturb && c == 11) begin
        start = 1'b0;
      end
    end
    chk({tag, "_latency"}, 256'(lat), 256'(got ? LAT : -1));
    last_hash = hash_p;
    if (has_exp && exp_hash_q.size() > 0) begin
      eh = exp_hash_q.pop_front();
      ei = exp_hin_q.pop_front();
      chk({tag, "_hash"}, hash_p, eh);
      chk({tag, "_alpha"}, alpha_p, lane_sub(eh, ei));
    end
  endtask

  initial begin
    #23;
    chk("rst_done", 256'(done), 256'd0);
    chk("rst_hash", hash_p, 256'd0);
    chk("rst_alpha", alpha_p, 256'd0);
    @(negedge clk);
    reset_n = 1'b1;

    run_block("abc", ABC_B, IV, IV, 1'b1, ABC_H, 1'b0);

    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (c % 5 == 0) begin
        chk("hold_done", 256'(done), 256'd1);
        chk("hold_hash", hash_p, ABC_H);
      end
    end

    run_block("empty", EMPTY_B, IV, IV, 1'b1, EMPTY_H, 1'b0);
    run_block("busy", ABC_B, IV, IV, 1'b1, ABC_H, 1'b1);

    run_block("blk1", TWO_B1, IV, IV, 1'b0, '0, 1'b0);
    run_block("blk2", TWO_B2, last_hash, last_hash, 1'b1, TWO_H, 1'b0);

    // abort an abc run after 30 cycles
    @(negedge clk);
    memory_block = ABC_B;
    hin_p = IV;
    ain_p = IV;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("abort_done", 256'(done), 256'd0);
    chk("abort_hash", hash_p, 256'd0);
    chk("abort_alpha", alpha_p, 256'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_hold", 256'(done), 256'd0);
    @(negedge clk);
    reset_n = 1'b1;

    run_block("abc2", ABC_B, IV, IV, 1'b1, ABC_H, 1'b0);
    chk("sb_empty", 256'(exp_hash_q.size()), 256'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
